// File: rtl/sniffer_pkg.sv
// Shared types and constants for the sniffer sample-RAM read side.
// Holds the drain FSM state encoding and the word-to-byte helper.
package sniffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

  // Little-endian byte select: index 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sniffer_readout_if.sv
// Read-only Wishbone port between the readout block and the sample RAM's second port.
interface sniffer_readout_if;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic        mem_we;
  logic        mem_stb;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        mem_stall;

  modport master (
    output mem_addr, mem_sel, mem_we, mem_stb,
    input  mem_data, mem_ack, mem_stall
  );

  modport slave (
    input  mem_addr, mem_sel, mem_we, mem_stb,
    output mem_data, mem_ack, mem_stall
  );
endinterface

// File: rtl/sniffer_readout_ser.sv
// 32-bit to byte serializer with valid/ready output and a last-byte handshake pulse.
module word_byte_ser
  import sniffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        last_o
);

  logic [31:0]      word_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic [7:0]       data_q;
  logic             hs_s;

  assign hs_s       = valid_q & tx_ready_i;
  assign last_o     = hs_s & (idx_q == LAST_IDX);
  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

  // Output byte is pre-selected one step ahead so tx_data_o stays a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= 32'h0000_0000;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else if (load_i) begin
      word_q  <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
      data_q  <= word_byte(word_i, 2'd0);
    end else if (last_o) begin
      valid_q <= 1'b0;
    end else if (hs_s) begin
      idx_q  <= idx_q + 2'd1;
      data_q <= word_byte(word_q, idx_q + 2'd1);
    end
  end

endmodule

// File: rtl/sniffer_readout.sv
// Drains capture words from the sample RAM in write order and streams them out
// little-endian as bytes; owns the read pointer and the Wishbone read port.
module sniffer_readout
  import sniffer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] wr_ptr_i,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W-1:0] level_o,
  output logic              busy_o,
  sniffer_readout_if.master mem,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  state_e            state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic              stb_q;
  logic [ADDR_W-1:0] level_s;
  logic [ADDR_W-1:0] level_d;
  logic              ser_load_s;
  logic              ser_last_s;

  assign rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
  assign level_s    = wr_ptr_i - rd_ptr_q;
  assign level_d    = wr_ptr_i - rd_ptr_d;
  assign ser_load_s = (state_q == WAIT) & mem.mem_ack;

  assign rd_ptr_o      = rd_ptr_q;
  assign level_o       = level_s;
  assign busy_o        = (state_q != IDLE);
  assign mem.mem_addr  = BASE_ADDR + 32'({rd_ptr_q, 2'b00});
  assign mem.mem_sel   = 4'hF;
  assign mem.mem_we    = 1'b0;
  assign mem.mem_stb   = stb_q;

  // Drain FSM; the strobe is registered alongside the state so it tracks REQ exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            rd_ptr_q <= '0;
          end else if (enable_i && (level_s != '0)) begin
            state_q <= REQ;
            stb_q   <= 1'b1;
          end
        end
        REQ: begin
          if (!mem.mem_stall) begin
            state_q <= WAIT;
            stb_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // A word is only retired on its last byte, so enable never truncates it.
          if (ser_last_s) begin
            rd_ptr_q <= rd_ptr_d;
            if (enable_i && (level_d != '0)) begin
              state_q <= REQ;
              stb_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

  word_byte_ser u_ser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ser_load_s),
    .word_i     (mem.mem_data),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .last_o     (ser_last_s)
  );

endmodule

// File: tb/tb_sniffer_readout.sv
// Self-checking bench: behavioural RAM/sink model with a byte-queue scoreboard,
// driven by a directed sequence plus randomized drains.
module tb_sniffer_readout;

  localparam int unsigned AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic          clear    = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] wr_ptr   = '0;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] level;
  logic          busy;
  logic [7:0]    tx_data;
  logic          tx_valid;

  sniffer_readout_if wb ();

  sniffer_readout #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .clear_i    (clear),
    .wr_ptr_i   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .level_o    (level),
    .busy_o     (busy),
    .mem        (wb),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [4];
  logic [7:0]  exp_q [$];
  logic [31:0] acc_addr_q [$];
  int          ready_mode   = 0;
  bit          rand_stall   = 1'b0;
  int          force_stalls = 0;
  int          n_accept     = 0;
  int          last_stb_len = 0;
  int          rx_cnt       = 0;
  logic [AW-1:0] m_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor-side model state
  logic          pend = 1'b0;
  logic [AW-1:0] pend_idx = '0;
  logic          prev_stb = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
  logic [31:0]   prev_addr = '0;
  logic [7:0]    prev_data = '0;
  int            cur_len = 0;
  int            byte_in_word = 0;
  logic [AW-1:0] mon_rd = '0;
  logic          new_acc;

  // RAM responder (1-cycle ack), stall/ready generator and byte scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0; wb.mem_ack = 1'b0; wb.mem_stall = 1'b0; wb.mem_data = 32'h0;
      exp_q.delete();
      prev_stb = 1'b0; prev_stall = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_busy = 1'b0;
      mon_rd = '0; byte_in_word = 0; cur_len = 0;
    end else begin
      if (prev_stb && prev_stall) begin
        chk("stb_held", 32'(wb.mem_stb), 32'd1);
        chk("addr_held", wb.mem_addr, prev_addr);
      end
      if (prev_stb && !prev_stall) chk("stb_single", 32'(wb.mem_stb), 32'd0);
      if (prev_valid && !prev_ready) begin
        chk("valid_held", 32'(tx_valid), 32'd1);
        chk("data_held", 32'(tx_data), 32'(prev_data));
      end
      if (wb.mem_stb && force_stalls > 0) begin
        wb.mem_stall = 1'b1;
        force_stalls--;
      end else begin
        wb.mem_stall = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (wb.mem_stb) begin
        chk("stb_addr", wb.mem_addr, BASE + (32'(mon_rd) << 2));
        chk("sel", 32'(wb.mem_sel), 32'hF);
        chk("we", 32'(wb.mem_we), 32'd0);
        cur_len++;
        if (!wb.mem_stall) begin
          n_accept++;
          last_stb_len = cur_len;
          cur_len = 0;
          acc_addr_q.push_back(wb.mem_addr);
        end
      end
      new_acc = wb.mem_stb && !wb.mem_stall;
      wb.mem_ack  = pend;
      wb.mem_data = pend ? ram[pend_idx] : $urandom;
      pend = new_acc;
      pend_idx = AW'((wb.mem_addr - BASE) >> 2);
      if (tx_valid && tx_ready) begin
        chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        rx_cnt++;
        byte_in_word++;
        if (byte_in_word == 4) begin
          byte_in_word = 0;
          mon_rd = mon_rd + 1'b1;
        end
      end
      if (clear && !prev_busy) mon_rd = '0;
      prev_stb = wb.mem_stb; prev_stall = wb.mem_stall; prev_addr = wb.mem_addr;
      prev_valid = tx_valid; prev_ready = tx_ready; prev_data = tx_data; prev_busy = busy;
    end
  end

  task automatic push_word(input logic [AW-1:0] idx);
    logic [31:0] w;
    w = ram[idx];
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
  endtask

  task automatic run_drain(input logic [AW-1:0] new_wr, input string tag);
    int words;
    int start_acc;
    bit done;
    logic [AW-1:0] d;
    d = new_wr - m_rd;
    words = int'(d);
    start_acc = n_accept;
    for (int k = 0; k < words; k++) push_word(m_rd + AW'(k));
    wr_ptr = new_wr;
    enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_rd"}, 32'(rd_ptr), 32'(new_wr));
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fetches"}, 32'(n_accept - start_acc), 32'(words));
    m_rd = new_wr;
  endtask

  initial begin
    bit seen;
    int start_rx;
    logic [AW-1:0] cwr;
    logic [31:0] a0, a1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd", 32'(rd_ptr), 32'd0);
    chk("rst_stb", 32'(wb.mem_stb), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", wb.mem_addr, BASE);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;

    // Basic drain
    ram[0] = 32'h4433_2211;
    ram[1] = 32'h8877_6655;
    ready_mode = 0;
    run_drain(2'd2, "basic");

    // Backpressure with alternating ready
    ram[2] = 32'hA5B6_C7D8;
    ready_mode = 1;
    run_drain(2'd3, "bp");

    // Three stall cycles on the request
    ready_mode = 0;
    ram[3] = $urandom;
    force_stalls = 3;
    run_drain(2'd0, "stall");
    chk("stall_stb_len", 32'(last_stb_len), 32'd4);

    // Randomized drains
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) ram[i] = $urandom;
      ready_mode = int'($urandom_range(0, 2));
      rand_stall = 1'($urandom_range(0, 1));
      run_drain(AW'($urandom_range(0, 3)), "rand");
    end

    // Wrap 3 -> 0
    ready_mode = 0;
    rand_stall = 1'b0;
    run_drain(2'd3, "wrap_pre");
    acc_addr_q.delete();
    run_drain(2'd1, "wrap");
    chk("wrap_nreq", 32'(acc_addr_q.size()), 32'd2);
    a0 = (acc_addr_q.size() > 0) ? acc_addr_q[0] : 32'hFFFF_FFFF;
    a1 = (acc_addr_q.size() > 1) ? acc_addr_q[1] : 32'hFFFF_FFFF;
    chk("wrap_addr0", a0, BASE + 32'h0000_000C);
    chk("wrap_addr1", a1, BASE);

    // Enable dropped mid-word, clear pulsed while busy
    enable = 1'b0;
    @(negedge clk); #1;
    push_word(m_rd);
    wr_ptr = m_rd + 2'd3;
    enable = 1'b1;
    start_rx = rx_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rx_cnt == start_rx + 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("endrop_reach", 32'(seen), 32'd1);
    enable = 1'b0;
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("endrop_done", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    m_rd = m_rd + 2'd1;
    chk("endrop_rd", 32'(rd_ptr), 32'(m_rd));
    chk("endrop_level", 32'(level), 32'd2);
    chk("endrop_idle", 32'(busy), 32'd0);

    // Clear in IDLE wins over a pending fetch
    cwr = m_rd ^ 2'b10;
    wr_ptr = cwr;
    @(negedge clk); #1;
    clear = 1'b1;
    enable = 1'b1;
    @(negedge clk); #1;
    chk("clear_prio_busy", 32'(busy), 32'd0);
    chk("clear_rd", 32'(rd_ptr), 32'd0);
    clear = 1'b0;
    m_rd = '0;
    run_drain(cwr, "post_clear");

    // Async reset during SHIFT
    for (int i = 0; i < 4; i++) ram[i] = $urandom;
    push_word(m_rd);
    push_word(m_rd + 2'd1);
    wr_ptr = m_rd + 2'd2;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("arst_reach", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_stb", 32'(wb.mem_stb), 32'd0);
    chk("arst_rd", 32'(rd_ptr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(tx_data), 32'd0);
    chk("arst_addr", wb.mem_addr, BASE);
    enable = 1'b0;
    wr_ptr = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    m_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("arst_after_busy", 32'(busy), 32'd0);

    // Normal operation after reset
    ram[0] = $urandom;
    ram[1] = $urandom;
    run_drain(2'd2, "final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sniffer_readout.md
# sniffer_readout

Read side of the USB sniffer sample RAM. The sniffer writes 32-bit capture words into the shared RAM through its write-only Wishbone master. This block drains those words in capture order through a read-only Wishbone master on the RAM's second port. It serializes each word into a valid/ready byte stream for the host link (FTDI TX path).

## Interface
Parameters:
- ADDR_W, 14: word-pointer width; the buffer holds 2^ADDR_W words and pointers wrap modulo 2^ADDR_W.
- BASE_ADDR, 32'h00000000: byte address of buffer word 0 on the Wishbone bus.

Ports:
- clk_i  in  1  single clock (ULPI 60 MHz domain).
- rst_ni  in  1  reset, asynchronous assert, active-low.
- enable_i  in  1  permits new word fetches.
- clear_i  in  1  sets the read pointer to 0; honoured only in IDLE.
- wr_ptr_i  in  ADDR_W  sniffer's next-write word index.
- rd_ptr_o  out  ADDR_W  next word index to read.
- level_o  out  ADDR_W  unread words: (wr_ptr_i - rd_ptr_o) mod 2^ADDR_W.
- busy_o  out  1  high in any state other than IDLE.
- mem_addr_o  out  32  byte address: BASE_ADDR + {rd_ptr, 2'b00}.
- mem_sel_o  out  4  fixed 4'hF.
- mem_we_o  out  1  fixed 0.
- mem_stb_o  out  1  request strobe.
- mem_data_i  in  32  read data.
- mem_ack_i  in  1  read data valid.
- mem_stall_i  in  1  request not accepted this cycle.
- tx_data_o  out  8  output byte.
- tx_valid_o  out  1  byte available.
- tx_ready_i  in  1  sink accepts the byte.

## Operation
- **Reset values.** rd_ptr_o=0, mem_stb_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, mem_addr_o=BASE_ADDR, state=IDLE.
- **IDLE**
  - If clear_i is high, rd_ptr becomes 0 and the state stays IDLE. clear_i takes priority over starting a fetch.
  - Otherwise, if enable_i is high and level_o≠0, go to REQ.
- **REQ**
  - mem_stb_o=1, with address held stable.
  - If mem_stall_i=0, go to WAIT. If mem_stall_i=1, stay in REQ with the strobe and address held.
- **WAIT**
  - mem_stb_o=0.
  - On mem_ack_i, latch mem_data_i into the shift register, set byte index=0, and go to SHIFT.
  - There is no timeout; the block waits for the ack indefinitely.
- **SHIFT**
  - tx_valid_o=1 and tx_data_o = word[8*idx+7 : 8*idx], little-endian (byte 0 = bits [7:0]).
  - Each handshake (tx_valid_o & tx_ready_i) increments idx.
  - On the handshake for idx=3, rd_ptr increments, wrapping 2^ADDR_W-1 → 0.
  - After that final handshake: go to REQ if enable_i is high and the post-increment level ≠ 0; otherwise go to IDLE.
- **Deasserting enable_i** never aborts a word. The current word always completes all 4 bytes.
- **clear_i outside IDLE** is ignored and is not latched.
- **Changes to wr_ptr_i** are sampled continuously. level_o is combinational from wr_ptr_i and the registered rd_ptr.
- **Overrun** (the writer lapping the reader) is not detected here; it is the sniffer's responsibility.
- mem_ack_i arriving outside WAIT is ignored.

## Timing
- IDLE → REQ takes 1 cycle. With zero stall and a 1-cycle RAM ack, the first byte is valid 3 cycles after leaving IDLE.
- With tx_ready_i held high, the 4 bytes go out on 4 consecutive cycles. The next REQ follows immediately.
- Steady-state throughput is 4 bytes per 6 cycles (REQ, WAIT, 4×SHIFT).
- tx_data_o and tx_valid_o are registered. tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- mem_stb_o is high for exactly 1 cycle per request when mem_stall_i=0.
- Asserting rst_ni low mid-operation immediately returns every output to its reset value. A pending ack is discarded.

## Structure
- Package sniffer_pkg holds:
  - the state enum {IDLE, REQ, WAIT, SHIFT};
  - the constant BYTES_PER_WORD=4.
- One sub-module, word_byte_ser, is natural:
  - it does the 32→8 serialization: load strobe, valid/ready output, and a last-byte pulse;
  - the top-level FSM owns the pointer and the Wishbone port.

## Test plan
- **Basic drain.** Reset, enable=1, wr_ptr=2, RAM[0]=32'h44332211, RAM[1]=32'h88776655, tx_ready=1 → bytes 11,22,33,44,55,66,77,88 in order; rd_ptr_o=2; level_o=0; busy_o falls.
- **Backpressure.** Toggle tx_ready 1/0 each cycle on 32'hA5B6C7D8 → bytes D8,C7,B6,A5 with no loss or duplication; data held stable while ready=0.
- **Stall.** mem_stall_i=1 for 3 cycles in REQ → stb and address (BASE_ADDR+0) held 4 cycles; exactly one ack is consumed.
- **Wrap.** ADDR_W=2, rd_ptr=3, wr_ptr=1 → reads words 3 then 0 (addresses 0xC, 0x0); rd_ptr_o=1.
- **Enable drop and clear.**
  - Drop enable during byte 1 of a word → bytes 2 and 3 still emitted, then IDLE.
  - clear_i pulsed while busy → ignored.
  - clear_i pulsed in IDLE → rd_ptr_o=0.
- **Async reset.** rst_ni low during SHIFT → tx_valid_o=0, mem_stb_o=0, rd_ptr_o=0 in the same cycle.
